// File: rtl/float_rand_responder_if.sv
// float_rand_responder_if: request/response bundle for float_rand_responder
//   call     : request, sampled every rising clock edge
//   data_out : half-precision random value in [0,1)
//   valid    : one-cycle pulse, data_out is new
//   busy     : responder is not idle
//   drop     : one-cycle pulse, a request was discarded
interface float_rand_responder_if;
  logic        call;
  logic [15:0] data_out;
  logic        valid;
  logic        busy;
  logic        drop;
  modport master (output call, input data_out, valid, busy, drop);
  modport slave  (input call, output data_out, valid, busy, drop);
endinterface

// File: rtl/float_rand_responder.sv
// float_rand_responder: LFSR-based uniform random source returning IEEE half-precision values in [0,1)
//   clock     : sole clock, rising edge
//   nreset    : asynchronous active-low reset
//   bus       : float_rand_responder_if.slave (call / data_out / valid / busy / drop)
//   seed_load, seed : runtime reseed in IDLE, present only with FLOAT_RAND_SEED_LOAD_EN defined
module float_rand_responder #(
  parameter int          STEPS = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic clock,
  input logic nreset,
`ifdef FLOAT_RAND_SEED_LOAD_EN
  input logic        seed_load,
  input logic [15:0] seed,
`endif
  float_rand_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GEN, CONV} state_t;
  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, sample_q, sample_d, data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d, valid_q, valid_d, drop_q, drop_d;
  logic        ld, idle, gen, conv, take;
  logic [15:0] ld_val;
`ifdef FLOAT_RAND_SEED_LOAD_EN
  assign ld     = seed_load;
  assign ld_val = seed == 16'h0 ? SEED : seed;
`else
  assign ld     = 1'b0;
  assign ld_val = SEED;
`endif
  // Sample is a 16-bit fraction of 2^16; subnormals cover 1..3, the rest normalise on the leading one.
  function automatic logic [15:0] to_half(input logic [15:0] s);
    logic [3:0] p;
    logic [9:0] m;
    p = 4'd0;
    for (int i = 0; i < 16; i++) if (s[i]) p = 4'(i);
    m = 10'((s << (4'd15 - p)) >> 5);
    to_half = s == 16'h0 ? 16'h0 : p < 4'd2 ? {6'b0, s[1:0], 8'b0} : {2'b00, p - 4'd1, m};
  endfunction
  assign idle = state_q == IDLE;
  assign gen  = state_q == GEN;
  assign conv = state_q == CONV;
  // A call during CONV with nothing pending is served at once, exactly as if it had been pended.
  assign take = (idle && bus.call && !ld) || (conv && (pend_q || bus.call));
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = take ? GEN : IDLE;
      GEN:     state_d = cnt_q == 5'(STEPS - 1) ? CONV : GEN;
      CONV:    state_d = take ? GEN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    lfsr_d   = idle && ld ? ld_val :
               gen ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    sample_d = take ? lfsr_q : sample_q;
    cnt_d    = take ? 5'd0 : gen ? cnt_q + 5'd1 : cnt_q;
    pend_d   = conv ? 1'b0 : gen && bus.call ? 1'b1 : pend_q;
    drop_d   = (gen || conv) && bus.call && pend_q;
    valid_d  = conv;
    data_d   = conv ? to_half(sample_q) : data_q;
  end
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      lfsr_q   <= SEED;
      sample_q <= 16'h0;
      cnt_q    <= 5'd0;
      pend_q   <= 1'b0;
      data_q   <= 16'h0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  always_comb begin
    bus.data_out = data_q;
    bus.valid    = valid_q;
    bus.drop     = drop_q;
    bus.busy     = state_q != IDLE;
  end
endmodule

// File: tb/tb_float_rand_responder.sv
// tb_float_rand_responder: self-checking bench for float_rand_responder against an arithmetic LFSR/half-float model
module tb_float_rand_responder;
  localparam int          STEPS = 16;
  localparam logic [15:0] SEED  = 16'hACE1;
  logic clock, nreset;
`ifdef FLOAT_RAND_SEED_LOAD_EN
  logic        seed_load;
  logic [15:0] seed;
`endif
  float_rand_responder_if bus ();
  float_rand_responder #(.STEPS(STEPS), .SEED(SEED)) dut (
    .clock(clock),
    .nreset(nreset),
`ifdef FLOAT_RAND_SEED_LOAD_EN
    .seed_load(seed_load),
    .seed(seed),
`endif
    .bus(bus)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int total = 0, bad = 0;
  int nv, nd, gaps, k, sign_bad, big_bad;
  logic [15:0] m_lfsr, got;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return {r[14:0], ^(r & 16'hB400)};
  endfunction
  // value = s / 65536 encoded as half precision, mantissa truncated
  function automatic logic [15:0] ref_half(input logic [15:0] s);
    int v, e;
    v = int'(s);
    if (v == 0) return 16'h0;
    if (v < 4) return 16'(v * 256);
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return 16'(((e - 1) << 10) | (((v - (1 << e)) * 1024) >> e));
  endfunction
  // next expected response in request order; advances the model generator
  function automatic logic [15:0] next_exp();
    logic [15:0] e;
    e = ref_half(m_lfsr);
    repeat (STEPS) m_lfsr = lfsr_next(m_lfsr);
    return e;
  endfunction
  task automatic see_valid(input string tag);
    chk(tag, bus.data_out, next_exp());
    if (bus.data_out[15]) sign_bad++;
    if (bus.data_out >= 16'h3C00) big_bad++;
  endtask
  task automatic run_req(output logic [15:0] obs);
    logic [15:0] e;
    int n;
    e = next_exp();
    bus.call = 1'b1;
    @(negedge clock);
    bus.call = 1'b0;
    chk("busy_after_accept", 16'(bus.busy), 16'h1);
    n = 0;
    while (n < 40 && bus.valid !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    chk("latency", 16'(n), 16'(STEPS + 1));
    chk("model_data", bus.data_out, e);
    obs = bus.data_out;
    @(negedge clock);
    chk("valid_one_cycle", 16'(bus.valid), 16'h0);
    chk("data_hold", bus.data_out, e);
    chk("idle_after", 16'(bus.busy), 16'h0);
  endtask
  initial begin
    bus.call = 1'b0;
    nreset   = 1'b0;
`ifdef FLOAT_RAND_SEED_LOAD_EN
    seed_load = 1'b0;
    seed      = 16'h0;
`endif
    sign_bad = 0;
    big_bad  = 0;
    m_lfsr   = SEED;
    repeat (2) @(negedge clock);
    chk("rst_data", bus.data_out, 16'h0);
    chk("rst_valid", 16'(bus.valid), 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_drop", 16'(bus.drop), 16'h0);
    nreset = 1'b1;
    run_req(got);
    chk("first_value", got, 16'h3967);
`ifdef FLOAT_RAND_SEED_LOAD_EN
    begin
      logic [15:0] seeds [5] = '{16'h8000, 16'hFFFF, 16'h0004, 16'h0003, 16'h0000};
      logic [15:0] wants [5] = '{16'h3800, 16'h3BFF, 16'h0400, 16'h0300, 16'h3967};
      for (int i = 0; i < 5; i++) begin
        seed_load = 1'b1;
        seed      = seeds[i];
        bus.call  = 1'b1;
        @(negedge clock);
        seed_load = 1'b0;
        bus.call  = 1'b0;
        chk("seed_beats_call", 16'(bus.busy), 16'h0);
        m_lfsr = seeds[i] == 16'h0 ? SEED : seeds[i];
        run_req(got);
        chk("seeded_value", got, wants[i]);
      end
    end
`endif
    nv = 0;
    nd = 0;
    gaps = 0;
    bus.call = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (i == 2) bus.call = 1'b0;
      if (bus.drop === 1'b1) nd++;
      if (bus.valid === 1'b1) begin
        nv++;
        see_valid("pend_data");
      end
      if (nv < 2 && bus.busy !== 1'b1) gaps++;
    end
    chk("pend_valids", 16'(nv), 16'h2);
    chk("pend_drops", 16'(nd), 16'h1);
    chk("pend_busy_gaps", 16'(gaps), 16'h0);
    chk("pend_idle", 16'(bus.busy), 16'h0);
    bus.call = 1'b1;
    @(negedge clock);
    bus.call = 1'b0;
    repeat (5) @(negedge clock);
    #2 nreset = 1'b0;
    #1;
    chk("midrst_data", bus.data_out, 16'h0);
    chk("midrst_valid", 16'(bus.valid), 16'h0);
    chk("midrst_busy", 16'(bus.busy), 16'h0);
    chk("midrst_drop", 16'(bus.drop), 16'h0);
    @(negedge clock);
    nreset = 1'b1;
    m_lfsr = SEED;
    nv = 0;
    repeat (30) begin
      @(negedge clock);
      if (bus.valid === 1'b1) nv++;
    end
    chk("midrst_no_valid", 16'(nv), 16'h0);
    run_req(got);
    chk("after_rst_value", got, 16'h3967);
    nv = 0;
    bus.call = 1'b1;
    k = 0;
    while (k < 1000 * (STEPS + 1) + 100 && nv < 1000) begin
      @(negedge clock);
      k++;
      if (bus.valid === 1'b1) begin
        nv++;
        see_valid("b2b_data");
      end
    end
    chk("b2b_count", 16'(nv), 16'(1000));
    nv = 0;
    k = 0;
    while (k < 8000 && nv < 200) begin
      bus.call = $urandom_range(0, 3) == 0;
      @(negedge clock);
      k++;
      if (bus.valid === 1'b1) begin
        nv++;
        see_valid("rand_data");
      end
    end
    chk("rand_count", 16'(nv), 16'(200));
    bus.call = 1'b0;
    repeat (3 * (STEPS + 2)) begin
      @(negedge clock);
      if (bus.valid === 1'b1) see_valid("drain_data");
    end
    chk("drain_idle", 16'(bus.busy), 16'h0);
    chk("sign_clear", 16'(sign_bad), 16'h0);
    chk("below_one", 16'(big_bad), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/float_rand_responder.md
FLOAT_RAND_RESPONDER -- requirements
Module: float_rand_responder

Interface
REQ-001 SHALL have parameter STEPS, default 16, LFSR advances per accepted request (legal 1..31).
REQ-002 SHALL have parameter SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port nreset  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port call  input  1  request; sampled on every rising edge.
REQ-006 SHALL have port data_out  output  16  IEEE half-precision value in [0,1).
REQ-007 SHALL have port valid  output  1  one-cycle pulse; data_out is new.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port drop  output  1  one-cycle pulse; a request was discarded.

Function
REQ-010 SHALL hold a 16-bit Fibonacci LFSR: shift left, bit0 <= r[15]^r[13]^r[12]^r[10], one shift per GEN cycle only.
REQ-011 SHALL implement states IDLE, GEN, CONV.
REQ-012 IDLE with call=1 at an edge SHALL copy the LFSR into a 16-bit sample register, clear the step counter, and go to GEN.
REQ-013 GEN SHALL shift the LFSR and increment the counter each edge; after exactly STEPS shifts it SHALL go to CONV.
REQ-014 CONV SHALL register data_out = convert(sample) and pulse valid for the following cycle.
REQ-015 Latency: valid SHALL be high in the cycle after the (STEPS+1)th edge following the accepting edge.
REQ-016 Conversion: sample=0 SHALL give 16'h0000.
REQ-017 Conversion: sample>=4 SHALL give sign 0, exponent 14-lz (lz = leading zeros), mantissa = the 10 bits below the leading one, zero-padded, truncated.
REQ-018 Conversion: sample 1..3 SHALL give exponent 0, mantissa = sample<<8 (subnormal).
REQ-019 call=1 sampled in GEN or CONV with no pending request SHALL set a one-deep pending flag.
REQ-020 call=1 sampled in GEN or CONV with pending set SHALL be discarded and pulse drop the next cycle.
REQ-021 CONV with pending set SHALL clear pending, take a new sample, and enter GEN directly; the valid pulse still occurs.
REQ-022 data_out SHALL hold its last value until the next valid.
REQ-023 valid and drop SHALL be low at all other times.

Reset
REQ-024 nreset low SHALL immediately force: state IDLE, LFSR=SEED, sample=0, counter=0, pending=0, data_out=0, valid=0, busy=0, drop=0.
REQ-025 Reset mid-request SHALL abandon it silently: no valid pulse after release.
REQ-026 The first edge after release SHALL be able to accept call.

Configuration
REQ-027 Macro FLOAT_RAND_SEED_LOAD_EN defined SHALL add ports seed_load (input, 1) and seed (input, 16).
REQ-028 With the macro, seed_load=1 in IDLE SHALL set LFSR=seed, or SEED if seed=0; it SHALL take priority over call that edge, and call SHALL be ignored.
REQ-029 With the macro, seed_load in GEN or CONV SHALL be ignored.
REQ-030 Without the macro, the ports SHALL be absent and the LFSR SHALL load only SEED at reset.

Verification
REQ-031 Bench: reset, STEPS=16, one call pulse -> valid 17 cycles later, data_out=16'h3967 (convert(16'hACE1)).
REQ-032 Bench (macro): seed_load seeds 16'h8000, 16'hFFFF, 16'h0004, 16'h0003, each then call -> data_out 16'h3800, 16'h3BFF, 16'h0400, 16'h0300.
REQ-033 Bench: call held high 3 cycles from IDLE -> second call pending; third call drops, drop pulses once; exactly two valid pulses, busy continuous between them.
REQ-034 Bench: nreset asserted in cycle 5 of GEN -> all outputs 0 at once; no valid afterward; next call returns 16'h3967.
REQ-035 Bench: 1000 back-to-back calls against a software LFSR/convert model -> every data_out matches, sign bit always 0, no value >= 16'h3C00.
